// File: rtl/dec_input_key_gen_if.sv
// Serial key/mode command bundle between a command source and the key decoder.
//   InputKey : serial key/mode bit, qualified by ValidCmd
//   ValidCmd : bit qualifier; low aborts entry or ends the active session
//   Active   : decoder has accepted key and mode
//   Mode     : captured mode while Active, else zero
//   Error    : one-cycle pulse after a key-bit mismatch
//   Locked   : decoder is in lockout after repeated mismatches
interface dec_input_key_gen_if #(
  parameter int unsigned MODE_W = 2
);
  logic              InputKey;
  logic              ValidCmd;
  logic              Active;
  logic [MODE_W-1:0] Mode;
  logic              Error;
  logic              Locked;

  modport master (
    output InputKey, ValidCmd,
    input  Active, Mode, Error, Locked
  );

  modport slave (
    input  InputKey, ValidCmd,
    output Active, Mode, Error, Locked
  );
endinterface

// File: rtl/dec_input_key_gen.sv
// Serial key decoder: matches a KEY_LEN-bit key (MSB first), then captures
// MODE_W mode bits and holds them while ValidCmd stays high. MAX_FAIL
// consecutive key mismatches lock the decoder out for LOCK_CYCLES cycles.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset
//   bus   : slave side of dec_input_key_gen_if (InputKey/ValidCmd in,
//           Active/Mode/Error/Locked out)
module dec_input_key_gen #(
  parameter int unsigned         KEY_LEN     = 4,
  parameter logic [KEY_LEN-1:0]  KEY         = 4'b1010,
  parameter int unsigned         MODE_W      = 2,
  parameter int unsigned         MAX_FAIL    = 3,
  parameter int unsigned         LOCK_CYCLES = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  dec_input_key_gen_if.slave bus
);

  localparam int unsigned CNT_MAX = (KEY_LEN > MODE_W) ? KEY_LEN : MODE_W;
  localparam int unsigned IDX_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned LCK_W   = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_MATCH    = 2'd0,
    S_MODE_CAP = 2'd1,
    S_ACTIVE   = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [FAIL_W-1:0] fail_cnt;
  logic [LCK_W-1:0]  lock_cnt;
  logic [MODE_W-1:0] mode_q;
  logic              err_q;
  logic              exp_bit;

  // Key bit expected at the current index (MSB of KEY is received first).
  always_comb begin
    exp_bit = 1'b0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (idx == IDX_W'(i)) exp_bit = KEY[KEY_LEN-1-i];
    end
  end

  // Decoder state machine with its counters and the Error pulse register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_MATCH;
      idx      <= '0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_MATCH: begin
          if (!bus.ValidCmd) begin
            idx <= '0;
          end else if (bus.InputKey == exp_bit) begin
            if (idx == IDX_W'(KEY_LEN - 1)) begin
              state <= S_MODE_CAP;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            // Mismatching bit is dropped; the next valid bit is key bit 0.
            idx   <= '0;
            err_q <= 1'b1;
            if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
              state    <= S_LOCKOUT;
              lock_cnt <= LCK_W'(LOCK_CYCLES);
              fail_cnt <= '0;
            end else begin
              fail_cnt <= fail_cnt + FAIL_W'(1);
            end
          end
        end

        S_MODE_CAP: begin
          if (!bus.ValidCmd) begin
            state <= S_MATCH;
            idx   <= '0;
          end else begin
            mode_q <= MODE_W'({mode_q, bus.InputKey});
            if (idx == IDX_W'(MODE_W - 1)) begin
              state    <= S_ACTIVE;
              idx      <= '0;
              fail_cnt <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        S_ACTIVE: begin
          if (!bus.ValidCmd) begin
            state <= S_MATCH;
            idx   <= '0;
          end
        end

        S_LOCKOUT: begin
          // Counter loaded with LOCK_CYCLES; leaving on the edge it hits 0
          // keeps Locked high for exactly LOCK_CYCLES cycles.
          if (lock_cnt <= LCK_W'(1)) begin
            state    <= S_MATCH;
            lock_cnt <= '0;
            idx      <= '0;
          end else begin
            lock_cnt <= lock_cnt - LCK_W'(1);
          end
        end

        default: begin
          state    <= S_MATCH;
          idx      <= '0;
          fail_cnt <= '0;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  assign bus.Active = (state == S_ACTIVE);
  assign bus.Mode   = (state == S_ACTIVE) ? mode_q : '0;
  assign bus.Locked = (state == S_LOCKOUT);
  assign bus.Error  = err_q;

endmodule

// File: doc/dec_input_key_gen.md
DEC_INPUT_KEY_GEN -- requirements
Module: dec_input_key_gen

Interface
REQ-001 Parameter KEY_LEN, default 4, number of key bits (>=1).
REQ-002 Parameter KEY, default 4'b1010, key pattern of KEY_LEN bits; MSB is received first.
REQ-003 Parameter MODE_W, default 2, number of mode bits following the key (>=1).
REQ-004 Parameter MAX_FAIL, default 3, consecutive key mismatches that trigger lockout (>=1).
REQ-005 Parameter LOCK_CYCLES, default 16, lockout duration in clock cycles (>=1).
REQ-006 Clk  input  1  single clock, all state updates on rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 InputKey  input  1  serial key/mode bit, sampled only when ValidCmd=1.
REQ-009 ValidCmd  input  1  qualifies InputKey; low aborts key/mode entry and ends ACTIVE.
REQ-010 Active  output  1  high while the decoder is in ACTIVE.
REQ-011 Mode  output  MODE_W  captured mode while Active=1, else all zero.
REQ-012 Error  output  1  one-cycle pulse on a key-bit mismatch.
REQ-013 Locked  output  1  high while in LOCKOUT.

Function
REQ-014 FSM states SHALL be MATCH, MODE_CAP, ACTIVE, LOCKOUT; Active, Mode and Locked SHALL be decoded from registered state only (Moore, no combinational path from inputs).
REQ-015 MATCH: bit index idx starts at 0; on an edge with ValidCmd=1 and InputKey==KEY[KEY_LEN-1-idx], idx increments; on the match of bit KEY_LEN-1, go to MODE_CAP with idx=0.
REQ-016 MATCH mismatch (ValidCmd=1, bit differs): idx<=0, fail_cnt increments, Error=1 for exactly the following cycle; no overlapping-pattern restart (mismatching bit is discarded).
REQ-017 MATCH mismatch with fail_cnt==MAX_FAIL-1: go to LOCKOUT, load lock counter with LOCK_CYCLES, Error still pulses, fail_cnt<=0.
REQ-018 MATCH or MODE_CAP with ValidCmd=0: idx<=0, remain/return to MATCH, fail_cnt unchanged, no Error.
REQ-019 MODE_CAP: each edge with ValidCmd=1 shifts InputKey into mode register MSB-first; after MODE_W bits go to ACTIVE and clear fail_cnt.
REQ-020 Active SHALL rise after the rising edge that samples the final mode bit, i.e. after edge KEY_LEN+MODE_W of an uninterrupted valid sequence.
REQ-021 ACTIVE: remain while ValidCmd=1 (InputKey ignored); on an edge with ValidCmd=0 go to MATCH, Active and Mode drop to 0 after that edge.
REQ-022 LOCKOUT: all inputs ignored; lock counter decrements each edge; on the edge where it reaches 0 go to MATCH with idx=0, Locked=1 for exactly LOCK_CYCLES cycles.
REQ-023 Counter widths: idx $clog2(max(KEY_LEN,MODE_W))+1, fail_cnt $clog2(MAX_FAIL+1), lock counter $clog2(LOCK_CYCLES+1); no counter SHALL wrap.
REQ-024 fail_cnt SHALL saturate at MAX_FAIL-1 and SHALL clear only on reset, successful entry to ACTIVE, or entry to LOCKOUT.
REQ-025 Unreachable state encodings SHALL return to MATCH on the next edge with all counters cleared.

Reset
REQ-026 Reset=1 SHALL immediately (without a clock edge) force state MATCH, idx=0, fail_cnt=0, lock counter=0, mode register=0, Active=0, Mode=0, Error=0, Locked=0.
REQ-027 Reset asserted mid-sequence, in ACTIVE or in LOCKOUT SHALL discard all progress; first valid bit after deassertion is key bit 0.

Verification (default parameters)
REQ-028 Reset, ValidCmd=1, bits 1,0,1,0,1,0 -> Active=1, Mode=2'b10 after 6th edge; Error, Locked stay 0.
REQ-029 From ACTIVE, hold ValidCmd=1 for 10 cycles with random InputKey, then ValidCmd=0 -> Active=1 throughout, Active=0 and Mode=0 after the first edge with ValidCmd=0.
REQ-030 Bits 1,1 -> Error=1 for one cycle after 2nd edge; then 1,0,1,0,0,1 -> Active=1, Mode=2'b01, fail_cnt cleared.
REQ-031 Three consecutive mismatches (bit 0 thrice) -> Locked=1 for 16 cycles; full valid key sent during lockout ignored (Active=0); same key after lockout -> Active=1.
REQ-032 Bits 1,0,1 then ValidCmd=0 one cycle -> no Error, fail_cnt unchanged; following 1,0,1,0,1,1 -> Mode=2'b11.
REQ-033 Reset pulsed between edges while Active=1, Mode=2'b10 -> Active, Mode, Error, Locked 0 before next edge.
